// File: rtl/escalonador_chamadas.sv
// Call scheduler: latches cabin/hall buttons into per-floor pending bits and
// issues each eligible floor once to the stop queue, cabin calls first, round-robin from the last issued floor.
module escalonador_chamadas #(
  parameter int N_ANDARES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 habilita,
  input  logic                 limpa,
  input  logic [N_ANDARES-1:0] botao_cabine,
  input  logic [N_ANDARES-1:0] botao_andar,
  input  logic                 servido,
  input  logic [3:0]           andar_servido,
  input  logic                 fila_cheia,
  output logic                 escreve_fila,
  output logic [3:0]           dado_fila,
  output logic [N_ANDARES-1:0] pend_cab,
  output logic [N_ANDARES-1:0] pend_and,
  output logic                 ocupado,
  output logic [1:0]           db_estado
);

  // state     | meaning
  // OCIOSO    | waiting for an eligible call while habilita is high
  // SELECIONA | floor latched in andarSel, checking it is still pending
  // ESPERA    | queue full, holding the selected floor
  // ESCREVE   | strobe the queue, mark floor enqueued, update ultimo
  typedef enum logic [1:0] {
    OCIOSO    = 2'b00,
    SELECIONA = 2'b01,
    ESCREVE   = 2'b10,
    ESPERA    = 2'b11
  } estado_t;

  localparam logic [N_ANDARES-1:0] MASCARA = {{(N_ANDARES-1){1'b1}}, 1'b0};

  estado_t              estado;
  logic [N_ANDARES-1:0] enfileirado;
  logic [N_ANDARES-1:0] eleg;
  logic [N_ANDARES-1:0] elegC;
  logic [N_ANDARES-1:0] busca;
  logic [N_ANDARES-1:0] cabNext;
  logic [N_ANDARES-1:0] andNext;
  logic [N_ANDARES-1:0] enfNext;
  logic [3:0]           ultimo;
  logic [3:0]           andarSel;
  logic [3:0]           vencedor;
  logic [3:0]           candidato;
  logic                 achou;
  logic                 selPendente;

  assign eleg        = (pend_cab | pend_and) & ~enfileirado & MASCARA;
  assign elegC       = pend_cab & ~enfileirado & MASCARA;
  assign busca       = (elegC != '0) ? elegC : eleg;
  assign selPendente = pend_cab[andarSel] | pend_and[andarSel];

  assign dado_fila = andarSel;
  assign ocupado   = (estado != OCIOSO);
  assign db_estado = estado;

  // Round-robin scan starting just after ultimo, floors 1..15 only.
  always_comb begin
    vencedor  = '0;
    candidato = '0;
    achou     = 1'b0;
    for (int k = 1; k < N_ANDARES; k++) begin
      candidato = 4'(((int'(ultimo) + k - 1) % (N_ANDARES - 1)) + 1);
      if (!achou && busca[candidato]) begin
        vencedor = candidato;
        achou    = 1'b1;
      end
    end
  end

  // Service clears after button OR, so a press on the floor being served is dropped;
  // the ESCREVE set is applied last so it wins over a same-cycle service.
  always_comb begin
    cabNext = (pend_cab | botao_cabine) & MASCARA;
    andNext = (pend_and | botao_andar) & MASCARA;
    enfNext = enfileirado;
    if (servido && (andar_servido != 4'd0)) begin
      cabNext[andar_servido] = 1'b0;
      andNext[andar_servido] = 1'b0;
      enfNext[andar_servido] = 1'b0;
    end
    if (estado == ESCREVE)
      enfNext[andarSel] = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= OCIOSO;
      pend_cab     <= '0;
      pend_and     <= '0;
      enfileirado  <= '0;
      ultimo       <= '0;
      andarSel     <= '0;
      escreve_fila <= 1'b0;
    end else if (limpa) begin
      estado       <= OCIOSO;
      pend_cab     <= '0;
      pend_and     <= '0;
      enfileirado  <= '0;
      ultimo       <= '0;
      escreve_fila <= 1'b0;
    end else begin
      pend_cab     <= cabNext;
      pend_and     <= andNext;
      enfileirado  <= enfNext;
      escreve_fila <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (habilita && (eleg != '0)) begin
            andarSel <= vencedor;
            estado   <= SELECIONA;
          end
        end
        SELECIONA, ESPERA: begin
          if (!selPendente) begin
            estado <= OCIOSO;
          end else if (fila_cheia) begin
            estado <= ESPERA;
          end else begin
            estado       <= ESCREVE;
            escreve_fila <= 1'b1;
          end
        end
        ESCREVE: begin
          ultimo <= andarSel;
          estado <= OCIOSO;
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_escalonador_chamadas.sv
// Bench for escalonador_chamadas: directed scenarios plus a randomized run
// checked against a per-floor pending/enqueued model with round-robin selection.
module tb_escalonador_chamadas;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        habilita = 1'b0;
  logic        limpa = 1'b0;
  logic [15:0] botao_cabine = '0;
  logic [15:0] botao_andar = '0;
  logic        servido = 1'b0;
  logic [3:0]  andar_servido = '0;
  logic        fila_cheia = 1'b0;
  logic        escreve_fila;
  logic [3:0]  dado_fila;
  logic [15:0] pend_cab;
  logic [15:0] pend_and;
  logic        ocupado;
  logic [1:0]  db_estado;

  int checks = 0;
  int errors = 0;
  int nWrites = 0;
  logic [3:0] writeLog[$];

  escalonador_chamadas #(.N_ANDARES(16)) dut (
    .clock(clock), .reset(reset), .habilita(habilita), .limpa(limpa),
    .botao_cabine(botao_cabine), .botao_andar(botao_andar),
    .servido(servido), .andar_servido(andar_servido), .fila_cheia(fila_cheia),
    .escreve_fila(escreve_fila), .dado_fila(dado_fila),
    .pend_cab(pend_cab), .pend_and(pend_and),
    .ocupado(ocupado), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (escreve_fila) begin
      nWrites++;
      writeLog.push_back(dado_fila);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference selection: cabin-eligible first, then scan ultimo+1 upward, 15 wraps to 1.
  function automatic logic [3:0] vencedorRef(input logic [15:0] c, input logic [15:0] a,
                                             input logic [15:0] e, input logic [3:0] u);
    logic [15:0] soCab, alvo;
    logic [3:0]  f, res;
    logic        ok;
    soCab = c & ~e & 16'hFFFE;
    alvo  = (c | a) & ~e & 16'hFFFE;
    if (soCab != 16'h0) alvo = soCab;
    f = u;
    res = 4'd0;
    ok = 1'b0;
    repeat (15) begin
      f = (f == 4'd15) ? 4'd1 : f + 4'd1;
      if (!ok && alvo[f]) begin
        res = f;
        ok = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic limpaEntradas();
    habilita = 1'b0; limpa = 1'b0; botao_cabine = '0; botao_andar = '0;
    servido = 1'b0; andar_servido = '0; fila_cheia = 1'b0;
  endtask

  task automatic doReset();
    limpaEntradas();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    writeLog.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({escreve_fila, dado_fila, pend_cab, pend_and, ocupado, db_estado} !== '0) begin
      errors++;
      $display("FAIL reset_async: outputs=%h required 0",
               {escreve_fila, dado_fila, pend_cab, pend_and, ocupado, db_estado});
    end
    doReset();
    checks++;
    if (db_estado !== 2'b00 || ocupado !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: db_estado=%b ocupado=%b required 00/0", db_estado, ocupado);
    end
    checks++;
    if (escreve_fila !== 1'b0 || pend_cab !== 16'h0 || pend_and !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: escreve=%b pend_cab=%h pend_and=%h required 0",
               escreve_fila, pend_cab, pend_and);
    end
  endtask

  task automatic test_single();
    int w0;
    doReset();
    habilita = 1'b1;
    w0 = nWrites;
    botao_cabine = 16'h0020;
    @(negedge clock);
    botao_cabine = '0;
    checks++;
    if (pend_cab !== 16'h0020 || escreve_fila !== 1'b0) begin
      errors++;
      $display("FAIL single_pend: pend_cab=%h escreve=%b required 0020/0", pend_cab, escreve_fila);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 2'b01) begin
      errors++;
      $display("FAIL single_seleciona: db_estado=%b required 01", db_estado);
    end
    @(negedge clock);
    checks++;
    if (escreve_fila !== 1'b1 || dado_fila !== 4'd5) begin
      errors++;
      $display("FAIL single_write: escreve=%b dado=%0d required 1/5", escreve_fila, dado_fila);
    end
    @(negedge clock);
    checks++;
    if (escreve_fila !== 1'b0 || db_estado !== 2'b00) begin
      errors++;
      $display("FAIL single_after: escreve=%b db_estado=%b required 0/00", escreve_fila, db_estado);
    end
    botao_cabine = 16'h0020;
    @(negedge clock);
    botao_cabine = '0;
    repeat (8) @(negedge clock);
    checks++;
    if (nWrites !== w0 + 1) begin
      errors++;
      $display("FAIL single_no_reissue: writes=%0d required %0d", nWrites - w0, 1);
    end
  endtask

  task automatic test_priority();
    logic [3:0] esperado[3];
    esperado[0] = 4'd7; esperado[1] = 4'd9; esperado[2] = 4'd2;
    doReset();
    habilita = 1'b1;
    botao_andar = 16'h0204;
    botao_cabine = 16'h0080;
    @(negedge clock);
    botao_andar = '0;
    botao_cabine = '0;
    for (int i = 0; i < 30 && writeLog.size() < 3; i++) @(negedge clock);
    checks++;
    if (writeLog.size() < 3) begin
      errors++;
      $display("FAIL priority_timeout: writes=%0d required 3", writeLog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (writeLog[i] !== esperado[i]) begin
          errors++;
          $display("FAIL priority_order[%0d]: floor=%0d required %0d", i, writeLog[i], esperado[i]);
        end
      end
    end
  endtask

  task automatic test_fila_cheia();
    int w0;
    doReset();
    habilita = 1'b1;
    fila_cheia = 1'b1;
    w0 = nWrites;
    botao_andar = 16'h0008;
    @(negedge clock);
    botao_andar = '0;
    repeat (5) @(negedge clock);
    checks++;
    if (db_estado !== 2'b11 || nWrites !== w0 || escreve_fila !== 1'b0) begin
      errors++;
      $display("FAIL full_hold: db_estado=%b writes=%0d required 11/0", db_estado, nWrites - w0);
    end
    fila_cheia = 1'b0;
    @(negedge clock);
    checks++;
    if (escreve_fila !== 1'b1 || dado_fila !== 4'd3) begin
      errors++;
      $display("FAIL full_release: escreve=%b dado=%0d required 1/3", escreve_fila, dado_fila);
    end
  endtask

  task automatic test_abort();
    int w0;
    doReset();
    habilita = 1'b1;
    fila_cheia = 1'b1;
    w0 = nWrites;
    botao_andar = 16'h0010;
    @(negedge clock);
    botao_andar = '0;
    repeat (2) @(negedge clock);
    checks++;
    if (db_estado !== 2'b11) begin
      errors++;
      $display("FAIL abort_espera: db_estado=%b required 11", db_estado);
    end
    servido = 1'b1;
    andar_servido = 4'd4;
    @(negedge clock);
    servido = 1'b0;
    andar_servido = 4'd0;
    checks++;
    if (pend_and !== 16'h0) begin
      errors++;
      $display("FAIL abort_pend: pend_and=%h required 0000", pend_and);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 2'b00) begin
      errors++;
      $display("FAIL abort_state: db_estado=%b required 00", db_estado);
    end
    fila_cheia = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (nWrites !== w0) begin
      errors++;
      $display("FAIL abort_nowrite: writes=%0d required 0", nWrites - w0);
    end
  endtask

  task automatic esperaEscrita(input string nome, input logic [3:0] andar);
    int w0;
    w0 = nWrites;
    for (int i = 0; i < 20 && nWrites == w0; i++) @(negedge clock);
    checks++;
    if (nWrites == w0) begin
      errors++;
      $display("FAIL %s_timeout: no write, required floor %0d", nome, andar);
    end else if (writeLog[writeLog.size()-1] !== andar) begin
      errors++;
      $display("FAIL %s: floor=%0d required %0d", nome, writeLog[writeLog.size()-1], andar);
    end
  endtask

  task automatic test_reissue();
    doReset();
    habilita = 1'b1;
    botao_cabine = 16'h0040;
    @(negedge clock);
    botao_cabine = '0;
    esperaEscrita("reissue_first", 4'd6);
    servido = 1'b1;
    andar_servido = 4'd6;
    @(negedge clock);
    servido = 1'b0;
    botao_cabine = 16'h0040;
    @(negedge clock);
    botao_cabine = '0;
    esperaEscrita("reissue_second", 4'd6);
  endtask

  task automatic test_habilita();
    int w0;
    doReset();
    w0 = nWrites;
    botao_cabine = 16'h0004;
    @(negedge clock);
    botao_cabine = '0;
    repeat (5) @(negedge clock);
    checks++;
    if (ocupado !== 1'b0 || nWrites !== w0) begin
      errors++;
      $display("FAIL habilita_gate: ocupado=%b writes=%0d required 0/0", ocupado, nWrites - w0);
    end
    habilita = 1'b1;
    esperaEscrita("habilita_release", 4'd2);
  endtask

  task automatic test_limpa_reset();
    int w0;
    doReset();
    habilita = 1'b1;
    fila_cheia = 1'b1;
    w0 = nWrites;
    botao_cabine = 16'h0008;
    botao_andar = 16'h0100;
    @(negedge clock);
    botao_cabine = '0;
    botao_andar = '0;
    repeat (3) @(negedge clock);
    limpa = 1'b1;
    fila_cheia = 1'b0;
    @(negedge clock);
    limpa = 1'b0;
    checks++;
    if (pend_cab !== 16'h0 || pend_and !== 16'h0 || db_estado !== 2'b00 || escreve_fila !== 1'b0) begin
      errors++;
      $display("FAIL limpa: pend_cab=%h pend_and=%h db_estado=%b escreve=%b required 0",
               pend_cab, pend_and, db_estado, escreve_fila);
    end
    fila_cheia = 1'b1;
    botao_cabine = 16'h0008;
    @(negedge clock);
    botao_cabine = '0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (pend_cab !== 16'h0 || db_estado !== 2'b00 || ocupado !== 1'b0 || escreve_fila !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: pend_cab=%h db_estado=%b ocupado=%b required 0",
               pend_cab, db_estado, ocupado);
    end
    @(negedge clock);
    reset = 1'b0;
    fila_cheia = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if (nWrites !== w0) begin
      errors++;
      $display("FAIL limpa_nowrite: writes=%0d required 0", nWrites - w0);
    end
  endtask

  task automatic test_random(input int ciclos, input int dreno);
    logic [15:0] mCab, mAnd, mEnf, pCab, pAnd, pEnf, alvo;
    logic [3:0]  mUlt, pUlt, expSel;
    logic        pOcup, pEsc, pHab, haveSel;
    int          f;
    doReset();
    mCab = '0; mAnd = '0; mEnf = '0; mUlt = '0;
    pCab = '0; pAnd = '0; pEnf = '0; pUlt = '0;
    pOcup = 1'b0; pEsc = 1'b0; pHab = 1'b0; haveSel = 1'b0; expSel = '0;
    for (int c = 0; c < ciclos + dreno; c++) begin
      checks++;
      if (pend_cab !== mCab || pend_and !== mAnd) begin
        errors++;
        $display("FAIL rand_pend c=%0d: pend_cab=%h pend_and=%h required %h/%h",
                 c, pend_cab, pend_and, mCab, mAnd);
      end
      if (ocupado && !pOcup) begin
        expSel = vencedorRef(pCab, pAnd, pEnf, pUlt);
        haveSel = 1'b1;
      end
      if (!pOcup && pHab && (((pCab | pAnd) & ~pEnf & 16'hFFFE) != 16'h0)) begin
        checks++;
        if (ocupado !== 1'b1) begin
          errors++;
          $display("FAIL rand_leave_idle c=%0d: ocupado=%b required 1", c, ocupado);
        end
      end
      if (escreve_fila) begin
        checks++;
        if (pEsc || !haveSel || dado_fila !== expSel) begin
          errors++;
          $display("FAIL rand_write c=%0d: floor=%0d back2back=%b required floor %0d",
                   c, dado_fila, pEsc, expSel);
        end
      end
      pCab = mCab; pAnd = mAnd; pEnf = mEnf; pUlt = mUlt;
      pOcup = ocupado; pEsc = escreve_fila;
      if (c < ciclos) begin
        botao_cabine = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(1, 15)) : 16'h0;
        botao_andar  = ($urandom_range(0, 3) == 0) ? (16'h1 << $urandom_range(1, 15)) : 16'h0;
        servido      = ($urandom_range(0, 4) == 0);
        alvo = mCab | mAnd | mEnf;
        f = int'($urandom_range(0, 15));
        if (alvo != 16'h0 && $urandom_range(0, 3) != 0) begin
          if (f == 0) f = 1;
          for (int t = 0; t < 16; t++)
            if (!alvo[f]) f = (f == 15) ? 1 : f + 1;
        end
        andar_servido = 4'(f);
        fila_cheia = ($urandom_range(0, 2) == 0);
        habilita   = ($urandom_range(0, 9) != 0);
      end else begin
        limpaEntradas();
        habilita = 1'b1;
      end
      pHab = habilita;
      mCab = (mCab | botao_cabine) & 16'hFFFE;
      mAnd = (mAnd | botao_andar) & 16'hFFFE;
      if (servido && andar_servido != 4'd0) begin
        mCab[andar_servido] = 1'b0;
        mAnd[andar_servido] = 1'b0;
        mEnf[andar_servido] = 1'b0;
      end
      if (escreve_fila) begin
        mEnf[expSel] = 1'b1;
        mUlt = expSel;
      end
      @(negedge clock);
    end
    checks++;
    if (((mCab | mAnd) & ~mEnf & 16'hFFFE) != 16'h0) begin
      errors++;
      $display("FAIL rand_drain: unissued=%h required 0000", (mCab | mAnd) & ~mEnf & 16'hFFFE);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_fila_cheia();
    test_abort();
    test_reissue();
    test_habilita();
    test_limpa_reset();
    test_random(3000, 60);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
